mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  EX-stage multiply/divide unit with private HI/LO registers. It executes
//  mult/multu/div/divu over a fixed multi-cycle latency and performs
//  mthi/mtlo in a single cycle. It drives the busy indication that the
//  hazard controller combines with start into its busy_real stall term.
//  mfhi/mflo read hi/lo through the datapath's EX result mux.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk    input   1   system clock, all state updates on rising edge
//  reset  input   1   synchronous, active-high; clears all state
//  start  input   1   one-cycle request, valid only with an arithmetic md_op
//  md_op  input   3   operation code (see md_defs.v)
//  we     input   1   write enable for MTHI/MTLO ops
//  a      input   32  forwarded GPR[rs] from EX
//  b      input   32  forwarded GPR[rt] from EX
//  busy   output  1   operation in flight
//  hi     output  32  HI register
//  lo     output  32  LO register
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high. On reset: busy=0,
//    hi=0, lo=0, counter=0, pending result=0.
//  - Ops: MULT {hi,lo}=$signed(a)*$signed(b); MULTU unsigned 64-bit product;
//    DIV lo=$signed(a)/$signed(b), hi=$signed(a)%$signed(b) (remainder sign
//    follows dividend); DIVU unsigned quotient/remainder.
//  - Divide by zero: op runs full DIV_CYCLES, then hi/lo are left unchanged.
//  - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
//  - Timing: start sampled at edge of cycle t. Operands are captured and the
//    result is computed into pending regs. Counter loads N (MULT_CYCLES or
//    DIV_CYCLES). busy=1 for cycles t+1..t+N. hi/lo are written at the end of
//    cycle t+N, so they are visible and busy=0 from cycle t+N+1.
//  - FSM: IDLE -> (start & arith op) -> RUN. RUN decrements the counter each
//    cycle; at counter==1 it commits hi/lo and returns to IDLE.
//  - start while busy: ignored. The controller must stall. No queueing, and
//    the in-flight op is unaffected.
//  - MTHI/MTLO (we=1, not busy): hi<=a or lo<=a at the edge, no busy.
//    we while busy: ignored.
//  - start and we in the same cycle: start wins, we ignored.
//  - start with a non-arithmetic md_op: ignored.
//  - Reset mid-RUN: op aborted, state per reset values the next cycle.
//  - hi/lo are registered outputs, never combinational from a/b.
// STRUCTURE
//  - md_defs.v (`include, shared with controller and datapath): `define
//    MD_MULT 3'd0, MD_MULTU 3'd1, MD_DIV 3'd2, MD_DIVU 3'd3, MD_MTHI 3'd4,
//    MD_MTLO 3'd5.
//  - Single module. Counter and FSM inline; behavioural * / % in one
//    always block. No sub-module needed.
//  - Controller stalls D on (start|busy) & IR_D is any md-type instruction.
// TESTING
//  1. reset=1 for 2 cycles -> busy=0, hi=0, lo=0.
//  2. MULT a=0xFFFFFFFE(-2), b=3, start@t -> busy high t+1..t+5;
//     t+6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
//  3. MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  4. DIV a=-7(0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD,
//     hi=0xFFFFFFFF. DIVU a=7, b=0 -> hi/lo keep prior values, busy 10 cycles.
//  5. MTLO a=0x12345678 while idle -> lo=0x12345678 next cycle, busy stays 0.
//     MTHI issued during a busy DIV -> ignored, and DIV result commits.
//  6. Start DIV, assert reset at 4th busy cycle -> next cycle busy=0, hi=lo=0.
//     A second start during busy -> ignored, and the first result is correct.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared opcodes, FSM states and the behavioural arithmetic for the mult/div unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  // Divide by zero yields wr=0 so the commit leaves HI/LO untouched.
  function automatic md_result_t md_compute(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    md_result_t r;
    logic [63:0] prod;
    r    = '0;
    prod = '0;
    case (op)
      MD_MULT: begin
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r    = '{wr: 1'b1, hi: prod[63:32], lo: prod[31:0]};
      end
      MD_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        r    = '{wr: 1'b1, hi: prod[63:32], lo: prod[31:0]};
      end
      MD_DIV: begin
        if (b == 32'd0) begin
          r.wr = 1'b0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = '{wr: 1'b1, hi: 32'd0, lo: 32'h8000_0000};
        end else begin
          r.wr = 1'b1;
          r.lo = $signed(a) / $signed(b);
          r.hi = $signed(a) % $signed(b);
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          r = '{wr: 1'b1, hi: a % b, lo: a / b};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div into private HI/LO,
// single-cycle mthi/mtlo, busy held for the whole arithmetic latency.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  md_result_t  pend_q, pend_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        start_ok;

  assign start_ok = start && md_is_arith(md_op) && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        // An accepted start takes priority over a move-to write in the same cycle.
        if (start_ok) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          pend_d  = md_compute(md_op, a, b);
        end else if (we && md_op == MD_MTHI) begin
          hi_d = a;
        end else if (we && md_op == MD_MTLO) begin
          lo_d = a;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_q.wr) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised scoreboard bench for mult_div_unit with a 64-bit arithmetic reference.
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset, start, we;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .we(we),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural meaning.
  task automatic model_arith(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p, qv, rv;
    exp_t e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      OP_MULT:  begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = 64'(x) * 64'(y); m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV: if (y != 0) begin
        q = sx / sy; r = sx % sy; qv = 64'(q); rv = 64'(r);
        m_lo = qv[31:0]; m_hi = rv[31:0];
      end
      default: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
    endcase
    e.hi = m_hi; e.lo = m_lo; e.len = op[1] ? N_DIV : N_MULT;
    sb_q.push_back(e);
  endtask

  // Monitor: on every busy falling edge, pop and compare the committed result.
  initial begin
    logic prev_busy;
    int   blen;
    exp_t e;
    prev_busy = 1'b0;
    blen = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen++;
      end else begin
        if (prev_busy) begin
          if (reset === 1'b1) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
          end else if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL commit: got unexpected busy drop expected none");
          end else begin
            e = sb_q.pop_front();
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
            chk("busy_len", 32'(blen), 32'(e.len));
          end
        end
        blen = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; we = 1'b0; md_op = op; a = x; b = y;
    model_arith(op, x, y);
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL timeout: got busy %b expected 0 within 40 cycles", busy);
    end
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] x);
    @(negedge clk);
    start = 1'b0; we = 1'b1; md_op = op; a = x;
    if (op == OP_MTHI) m_hi = x; else m_lo = x;
    @(negedge clk);
    we = 1'b0;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    chk("mt_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp[5];
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic [2:0] op;
    reset = 1'b1; start = 1'b0; we = 1'b0; md_op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi_const", hi, 32'h0000_0001);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle();

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_lo_const", lo, 32'h8000_0000);

    mt(OP_MTLO, 32'h1234_5678);
    mt(OP_MTHI, 32'hCAFE_F00D);

    // MTHI and a second start while a DIV is in flight must both be ignored.
    issue(OP_DIV, 32'd100, 32'd7);
    start = 1'b1; md_op = OP_MULT; a = $urandom(); b = $urandom();
    @(negedge clk);
    start = 1'b0; we = 1'b1; md_op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    wait_idle();

    // Non-arithmetic start while idle: nothing happens.
    @(negedge clk);
    start = 1'b1; we = 1'b0; md_op = OP_MTLO; a = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0;
    chk("nonarith_busy", 32'(busy), 32'd0);
    chk("nonarith_lo", lo, m_lo);

    // Reset during the 4th busy cycle aborts the op.
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 5));
      if (op == OP_MTHI || op == OP_MTLO) begin
        mt(op, $urandom());
      end else begin
        issue(op, pick(), ($urandom_range(0, 5) == 0) ? 32'd0 : pick());
        wait_idle();
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
